// File: rtl/ofifo_pkg.sv
// Shared types and sizing for the MAC-array output collector.
package ofifo_pkg;
   localparam int COL     = 8;
   localparam int PSUM_BW = 16;
   localparam int DEPTH   = 64;
   localparam int PTR_W   = $clog2(DEPTH) + 1;

   typedef logic [PSUM_BW-1:0] psum_t;
endpackage

// File: rtl/ofifo_if.sv
// Collector handshake bundle: array psums in, aligned rows out.
interface ofifo_if;
   import ofifo_pkg::*;

   psum_t [COL-1:0] in;
   logic  [COL-1:0] wr;
   logic            rd;
   logic            o_valid;
   logic            o_full;
   logic            o_ready;
   psum_t [COL-1:0] out;
   logic            out_vld;
   logic            o_err;

   modport master (output in, wr, rd,
                   input  o_valid, o_full, o_ready, out, out_vld, o_err);
   modport slave  (input  in, wr, rd,
                   output o_valid, o_full, o_ready, out, out_vld, o_err);
endinterface

// File: rtl/ofifo_col.sv
// Single-column psum FIFO; pointers carry a wrap bit to tell full from empty.
module ofifo_col import ofifo_pkg::*; #(
   parameter int psum_bw = PSUM_BW,
   parameter int depth   = DEPTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr,
   input  logic               pop,
   input  logic [psum_bw-1:0] din,
   output logic               full,
   output logic               empty,
   output logic [psum_bw-1:0] head
);
   localparam int AW = $clog2(depth);
   localparam int PW = AW + 1;

   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [psum_bw-1:0] mem_q [depth];
   logic               wr_acc;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   // A pop frees the head slot this edge, so a write into a full column still lands.
   always_comb begin
      wr_acc   = wr && (!full || pop);
      wr_ptr_d = wr_ptr_q + PW'(wr_acc);
      rd_ptr_d = rd_ptr_q + PW'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/ofifo_collector.sv
// Per-column FIFOs that re-align skewed MAC-array psums into full output rows.
module ofifo_collector import ofifo_pkg::*; #(
   parameter int col     = COL,
   parameter int psum_bw = PSUM_BW,
   parameter int depth   = DEPTH
) (
   input  logic  clk,
   input  logic  reset,
   ofifo_if.slave bus
);
   logic [col-1:0]              full_c, empty_c;
   logic [col-1:0][psum_bw-1:0] head;
   logic [col-1:0][psum_bw-1:0] out_q, out_d;
   logic                        out_vld_q, out_vld_d;
   logic                        err_q, err_d;
   logic                        o_valid, pop, drop, underflow;

   for (genvar c = 0; c < col; c++) begin : g_col
      ofifo_col #(.psum_bw(psum_bw), .depth(depth)) u_col (
         .clk   (clk),
         .reset (reset),
         .wr    (bus.wr[c]),
         .pop   (pop),
         .din   (bus.in[c]),
         .full  (full_c[c]),
         .empty (empty_c[c]),
         .head  (head[c])
      );
   end

   // Status is derived only from pointer state, never from same-cycle wr/rd.
   assign o_valid     = ~|empty_c;
   assign bus.o_valid = o_valid;
   assign bus.o_full  = |full_c;
   assign bus.o_ready = ~|full_c;
   assign bus.out     = out_q;
   assign bus.out_vld = out_vld_q;
   assign bus.o_err   = err_q;

   always_comb begin
      pop       = bus.rd && o_valid;
      underflow = bus.rd && !o_valid;
      drop      = |(bus.wr & full_c) && !pop;
      out_d     = pop ? head : out_q;
      out_vld_d = pop;
      err_d     = err_q || underflow || drop;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q     <= '0;
         out_vld_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         err_q     <= err_d;
      end
   end
endmodule

// File: tb/tb_ofifo_collector.sv
// Directed bench with a queue-based reference model checked every cycle.
module tb_ofifo_collector;
   import ofifo_pkg::*;

   typedef psum_t [COL-1:0] row_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   ofifo_if bus();

   ofifo_collector dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // Reference model: one queue per column, outputs derived from queue occupancy.
   psum_t q [COL][$];
   row_t  m_out = '0;
   logic  m_vld = 1'b0;
   logic  m_err = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge reset) begin : model
      logic v, pop;
      if (reset) begin
         for (int c = 0; c < COL; c++) q[c].delete();
         m_out <= '0;
         m_vld <= 1'b0;
         m_err <= 1'b0;
      end else begin
         v = 1'b1;
         for (int c = 0; c < COL; c++) if (q[c].size() == 0) v = 1'b0;
         pop = bus.rd && v;
         m_vld <= pop;
         if (bus.rd && !v) m_err <= 1'b1;
         for (int c = 0; c < COL; c++)
            if (bus.wr[c] && q[c].size() == DEPTH && !pop) m_err <= 1'b1;
         if (pop) begin
            for (int c = 0; c < COL; c++) m_out[c] <= q[c].pop_front();
         end
         for (int c = 0; c < COL; c++)
            if (bus.wr[c] && q[c].size() < DEPTH) q[c].push_back(bus.in[c]);
      end
   end

   always @(negedge clk) begin : compare
      logic ev, ef;
      ev = 1'b1;
      ef = 1'b0;
      for (int c = 0; c < COL; c++) begin
         if (q[c].size() == 0) ev = 1'b0;
         if (q[c].size() == DEPTH) ef = 1'b1;
      end
      chk("cmp_o_valid", bus.o_valid, ev);
      chk("cmp_o_full", bus.o_full, ef);
      chk("cmp_o_ready", bus.o_ready, !ef);
      chk("cmp_out_vld", bus.out_vld, m_vld);
      chk("cmp_out", bus.out, m_out);
      chk("cmp_o_err", bus.o_err, m_err);
   end

   function automatic row_t fill(input psum_t v);
      row_t r;
      for (int c = 0; c < COL; c++) r[c] = v;
      return r;
   endfunction

   task automatic drive(input logic [COL-1:0] w, input logic r, input row_t d);
      bus.wr = w;
      bus.rd = r;
      bus.in = d;
      @(posedge clk);
      #1;
      bus.wr = '0;
      bus.rd = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      row_t d;
      bus.wr = '0;
      bus.rd = 1'b0;
      bus.in = '0;
      reset  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", bus.out, 128'h0);
      chk("rst_out_vld", bus.out_vld, 1'b0);
      chk("rst_o_err", bus.o_err, 1'b0);
      chk("rst_o_valid", bus.o_valid, 1'b0);
      chk("rst_o_full", bus.o_full, 1'b0);
      chk("rst_o_ready", bus.o_ready, 1'b1);
      reset = 1'b0;

      // Skewed fill: row becomes available only after the last column lands.
      for (int c = 0; c < COL; c++) begin
         d = '0;
         d[c] = 16'h0100 + 16'(c);
         drive(8'(1 << c), 1'b0, d);
         chk("skew_o_valid", bus.o_valid, c == COL - 1);
      end
      drive('0, 1'b1, '0);
      chk("skew_out_vld", bus.out_vld, 1'b1);
      for (int c = 0; c < COL; c++) chk("skew_out", bus.out[c], 16'h0100 + 16'(c));
      drive('0, 1'b0, '0);
      chk("skew_vld_drop", bus.out_vld, 1'b0);
      chk("skew_valid_fall", bus.o_valid, 1'b0);

      // Underflow: ignored, flagged, out holds.
      drive('0, 1'b1, '0);
      chk("uf_out_vld", bus.out_vld, 1'b0);
      chk("uf_out_hold", bus.out[0], 16'h0100);
      chk("uf_o_err", bus.o_err, 1'b1);
      for (int c = 0; c < COL; c++) d[c] = 16'h0200 + 16'(c);
      drive('1, 1'b0, d);
      chk("uf_o_valid", bus.o_valid, 1'b1);
      drive('0, 1'b1, '0);
      chk("uf_pop", bus.out[3], 16'h0203);

      // Full plus simultaneous write and pop.
      do_reset();
      for (int i = 0; i < DEPTH; i++) drive('1, 1'b0, fill(psum_t'(i)));
      chk("full_o_full", bus.o_full, 1'b1);
      chk("full_o_ready", bus.o_ready, 1'b0);
      drive('1, 1'b1, fill(16'hBEEF));
      chk("wp_o_err", bus.o_err, 1'b0);
      chk("wp_o_full", bus.o_full, 1'b1);
      chk("wp_out", bus.out, fill(16'h0000));
      for (int k = 1; k < DEPTH; k++) begin
         drive('0, 1'b1, '0);
         chk("wp_drain", bus.out[k % COL], 16'(k));
      end
      drive('0, 1'b1, '0);
      chk("wp_new", bus.out, fill(16'hBEEF));
      chk("wp_empty", bus.o_valid, 1'b0);

      // Fill to full, drop one write.
      for (int i = 0; i < DEPTH; i++) drive('1, 1'b0, fill(psum_t'(i)));
      drive('1, 1'b0, fill(16'hDEAD));
      chk("drop_o_err", bus.o_err, 1'b1);
      for (int k = 0; k < DEPTH; k++) begin
         drive('0, 1'b1, '0);
         chk("drop_drain", bus.out[(k + 5) % COL], 16'(k));
      end
      chk("drop_empty", bus.o_valid, 1'b0);

      // Wrap-around at constant occupancy of three rows.
      do_reset();
      for (int k = 0; k < 3; k++) drive('1, 1'b0, fill(16'h4000 + 16'(k)));
      for (int i = 0; i < 200; i++) begin
         drive('1, 1'b1, fill(16'h4000 + 16'(i + 3)));
         chk("wrap_out", bus.out[i % COL], 16'h4000 + 16'(i));
      end
      chk("wrap_no_full", bus.o_full, 1'b0);
      chk("wrap_no_err", bus.o_err, 1'b0);

      // Async reset mid-stream with 10 rows stored and o_err set.
      do_reset();
      drive('0, 1'b1, '0);
      for (int k = 0; k < 11; k++) drive('1, 1'b0, fill(16'h0300 + 16'(k)));
      drive('0, 1'b1, '0);
      chk("ar_pre_err", bus.o_err, 1'b1);
      chk("ar_pre_out", bus.out[2], 16'h0300);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_o_valid", bus.o_valid, 1'b0);
      chk("ar_out", bus.out, 128'h0);
      chk("ar_o_err", bus.o_err, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive('0, 1'b0, '0);
      chk("ar_o_ready", bus.o_ready, 1'b1);
      chk("ar_empty", bus.o_valid, 1'b0);

      @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ofifo_collector.md
Name: ofifo_collector

Overview:
- Output collection stage directly downstream of the 8x8 MAC array.
- Captures each column's out_s psum independently, whenever that column's valid bit fires.
- Columns finish at staggered cycles, so each column has its own FIFO. A full-width row is released only when every column holds at least one entry, which re-aligns the skewed psums into complete output vectors for the SFU/accumulation stage and memory write-back.

Parameters:
- col, 8, number of MAC columns (one FIFO per column)
- psum_bw, 16, width of one psum entry
- depth, 64, entries per column FIFO (power of two, >=2)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in  input  col*psum_bw  packed [col-1:0][psum_bw-1:0] psums from array out_s
- wr  input  col  per-column write strobe (array valid)
- rd  input  1  request to pop one full row
- o_valid  output  1  every column FIFO non-empty (row available)
- o_full  output  1  any column FIFO full
- o_ready  output  1  no column FIFO full (= !o_full)
- out  output  col*psum_bw  popped row, packed like in
- out_vld  output  1  out holds newly popped row this cycle
- o_err  output  1  sticky: write dropped on full column, or rd while !o_valid

Behaviour:
- Reset (async, active-high):
  - All pointers are cleared.
  - Outputs: out=0, out_vld=0, o_err=0, o_valid=0, o_full=0, o_ready=1.
  - Reset mid-operation discards all stored data immediately. No output change follows until new writes arrive.
- Each column FIFO has its own wr_ptr and a shared-semantics rd_ptr, both log2(depth)+1 bits with a wrap bit:
  - empty_c = (wr_ptr==rd_ptr).
  - full_c = (MSBs differ, LSBs equal).
- Write, per column c:
  - Accepted on posedge when wr[c] && (!full_c || pop).
  - in[c] is stored at wr_ptr[c], and wr_ptr[c] increments, wrapping modulo 2*depth.
- Pop:
  - pop = rd && o_valid.
  - On a pop, every column's rd_ptr increments together.
  - out is registered with the head entries of all columns, and out_vld=1 on the following cycle. This gives 1-cycle read latency.
  - out_vld is 0 in any cycle with no preceding pop. out holds its last value.
- Simultaneous write and pop on a full column: both are accepted, and the count is unchanged.
- Simultaneous write and pop on an empty column: cannot occur, because pop requires all columns non-empty.
- Dropped write (wr[c] && full_c && !pop):
  - Data is discarded and pointers are unchanged.
  - o_err is set and stays set until reset.
- rd while !o_valid: ignored (no pointer change, out_vld=0), and o_err is set.
- o_valid, o_full and o_ready are combinational from the pointer registers only. They never depend on same-cycle wr/rd.
- Columns are fully independent for writes. Arbitrary skew between columns is tolerated up to depth entries.
- No arithmetic is applied to data. psums are stored bit-exact.

Decomposition:
- Shared package ofifo_pkg:
  - PSUM_BW and COL defaults.
  - localparam PTR_W = $clog2(depth)+1.
  - typedef psum_t = logic [PSUM_BW-1:0].
- One natural sub-module: ofifo_col, a single-column FIFO with wr, pop, full, empty and head-data ports.
- ofifo_collector instantiates col copies of ofifo_col via generate. It adds the all-empty reduction, the pop logic, the out register and the sticky error flag.

Test Plan:
- Skewed fill:
  - Stimulus: write column c with value 16'h0100+c at cycle c (c=0..7), then rd.
  - Required: o_valid rises only on the cycle after column 7's write. out_vld pulses 1 cycle after rd with out[c]=16'h0100+c. o_valid then falls.
- Fill to full:
  - Stimulus: 64 writes to all columns with values 0..63.
  - Required: o_full=1 and o_ready=0 after the 64th write. A 65th write with value 16'hDEAD is dropped and o_err=1. 64 pops return 0..63 in order, then o_valid=0.
- Full plus simultaneous write and pop:
  - Stimulus: with all columns full, assert wr=8'hFF and rd in the same cycle.
  - Required: o_err stays 0 and o_full stays 1. Popped data = oldest entry, and the new data appears after 63 further pops.
- Underflow:
  - Stimulus: rd with empty FIFOs.
  - Required: out_vld=0, out unchanged, o_err=1, pointers unchanged (a subsequent single full-row write makes o_valid=1).
- Wrap-around:
  - Stimulus: 200 interleaved write/pop cycles with an occupancy of about 3.
  - Required: every popped row equals the written sequence (scoreboard), with no spurious full/empty.
- Async reset mid-stream:
  - Stimulus: assert reset between clock edges with 10 entries stored.
  - Required: o_valid=0, out=0, o_err=0 immediately without waiting for a clock edge. After release, o_ready=1.
